// File: rtl/fetch_align_if.sv
// Memory-fetch, redirect and decode-side signals of the instruction aligner.
// Signal prefixes are from the aligner's point of view (slave modport).
interface fetch_align_if;
   logic        O_memreq;
   logic [31:0] O_memaddr;
   logic        I_memack;
   logic [31:0] I_memdata;
   logic        I_redirect;
   logic [31:0] I_redirectpc;
   logic        O_valid;
   logic        I_ready;
   logic [31:0] O_instr;
   logic [31:0] O_pc;

   modport slave (
      output O_memreq, O_memaddr, O_valid, O_instr, O_pc,
      input  I_memack, I_memdata, I_redirect, I_redirectpc, I_ready
   );

   modport master (
      input  O_memreq, O_memaddr, O_valid, O_instr, O_pc,
      output I_memack, I_memdata, I_redirect, I_redirectpc, I_ready
   );
endinterface

// File: rtl/fetch_align.sv
// Splits word-aligned fetches into halfwords and presents one RV32I/RV32C instruction
// per handshake, including 32-bit instructions straddling a word boundary.
module fetch_align #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic          I_clk,
   input logic          I_rst,
   fetch_align_if.slave bus
);
   typedef enum logic {S_ALIGNED = 1'b0, S_SKIP = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [15:0] hw_q [3];
   logic [15:0] hw_d [3];
   logic [15:0] shifted [3];
   logic [1:0]  count_q, count_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fpc_q, fpc_d;

   logic        is32, valid, memreq, xfer, consume;
   logic [1:0]  consumed, remain, appended;
   logic [15:0] app_first, app_second;

   assign is32     = (hw_q[0][1:0] == 2'b11);
   assign valid    = ((count_q >= 2'd1) && !is32) || (count_q >= 2'd2);
   assign memreq   = !I_rst && (count_q <= 2'd1);
   assign xfer     = memreq && bus.I_memack;
   assign consume  = valid && bus.I_ready;
   assign consumed = !consume ? 2'd0 : (is32 ? 2'd2 : 2'd1);
   assign remain   = count_q - consumed;

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q <= RESET_PC[1] ? S_SKIP : S_ALIGNED;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.I_redirect) begin
         state_d = bus.I_redirectpc[1] ? S_SKIP : S_ALIGNED;
      end else if (xfer) begin
         state_d = S_ALIGNED;
      end
   end

   // A fetch after an odd-halfword target only keeps the upper half of the word.
   always_comb begin
      appended   = 2'd0;
      app_first  = bus.I_memdata[15:0];
      app_second = bus.I_memdata[31:16];
      case (state_q)
         S_ALIGNED: appended = xfer ? 2'd2 : 2'd0;
         S_SKIP: begin
            appended  = xfer ? 2'd1 : 2'd0;
            app_first = bus.I_memdata[31:16];
         end
         default: appended = 2'd0;
      endcase
   end

   always_comb begin
      shifted[0] = hw_q[0];
      shifted[1] = hw_q[1];
      shifted[2] = hw_q[2];
      if (consumed == 2'd1) begin
         shifted[0] = hw_q[1];
         shifted[1] = hw_q[2];
      end else if (consumed == 2'd2) begin
         shifted[0] = hw_q[2];
      end
   end

   // New halfwords land right after whatever survives the consume.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_slot
         assign hw_d[gi] = (xfer && (remain == 2'(gi)))                             ? app_first  :
                           (xfer && (appended == 2'd2) && (remain + 2'd1 == 2'(gi))) ? app_second :
                                                                                       shifted[gi];
      end
   endgenerate

   always_comb begin
      count_d = remain + appended;
      pc_d    = consume ? (pc_q + (is32 ? 32'd4 : 32'd2)) : pc_q;
      fpc_d   = xfer ? (fpc_q + 32'd4) : fpc_q;
      if (bus.I_redirect) begin
         count_d = 2'd0;
         pc_d    = bus.I_redirectpc & ~32'h1;
         fpc_d   = bus.I_redirectpc & ~32'h3;
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         count_q <= 2'd0;
         pc_q    <= RESET_PC;
         fpc_q   <= RESET_PC & ~32'h3;
         for (int i = 0; i < 3; i++) begin
            hw_q[i] <= 16'h0000;
         end
      end else begin
         count_q <= count_d;
         pc_q    <= pc_d;
         fpc_q   <= fpc_d;
         for (int i = 0; i < 3; i++) begin
            hw_q[i] <= hw_d[i];
         end
      end
   end

   assign bus.O_memreq  = memreq;
   assign bus.O_memaddr = fpc_q;
   assign bus.O_valid   = valid;
   assign bus.O_pc      = pc_q;
   assign bus.O_instr   = is32 ? {hw_q[1], hw_q[0]} : {16'h0000, hw_q[0]};
endmodule
